// File: rtl/uart_pkg.sv
// Shared types and constants for the word-wide UART transmitter.
package uart_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned NBYTE_W       = 2;
  localparam int unsigned BIT_IDX_W     = 3;
  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 8;
  localparam int unsigned MAX_STOP_BITS = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } sm_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  // Word latched on a transfer; the divisor is held separately since its width is a parameter.
  typedef struct packed {
    logic [WORD_W-1:0]  data;
    logic [NBYTE_W-1:0] nbytes;
  } word_req_t;

  // XOR of the low nbits of a byte lane, optionally inverted for odd parity.
  function automatic logic char_parity(input logic [BYTE_W-1:0] b,
                                       input int unsigned       nbits,
                                       input logic              odd);
    logic p;
    p = 1'b0;
    for (int unsigned k = 0; k < BYTE_W; k++) begin
      if (k < nbits) p = p ^ b[3'(k)];
    end
    return p ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: reloadable down-counter with a registered tick on the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  // Tick is predicted one cycle early so it can be registered; i_div is always >= 1 here.
  always_comb begin
    w_cnt_nxt  = '0;
    w_tick_nxt = 1'b0;
    if (i_load || (i_en && (r_cnt == '0))) begin
      w_cnt_nxt = i_div - DIV_W'(1);
    end else if (i_en) begin
      w_cnt_nxt = r_cnt - DIV_W'(1);
    end
    w_tick_nxt = (i_load || i_en) && (w_cnt_nxt == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_tx_word.sv
// UART transmitter serialising 1-4 byte lanes of a 32-bit word, LSB lane first, with
// parametrised character width, parity and stop bits.
module uart_tx_word
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WORD_W-1:0]  i_data,
  input  logic [NBYTE_W-1:0] i_nbytes,
  input  logic [DIV_W-1:0]   i_div,
  input  logic               i_valid,
  output logic               o_accept,
  output logic               o_tx,
  output logic               o_busy
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit                   HAS_PAR   = (PARITY != 0);
  localparam logic                 PAR_INV   = (PARITY == 32'(PAR_ODD));

  sm_t                  r_state;
  sm_t                  w_state_nxt;
  word_req_t            r_req;
  logic [DIV_W-1:0]     r_div;
  logic [DIV_W-1:0]     w_div_in;
  logic [DIV_W-1:0]     w_div_sel;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [BIT_IDX_W-1:0] w_bit_idx_nxt;
  logic [NBYTE_W-1:0]   r_byte_idx;
  logic [NBYTE_W-1:0]   w_byte_idx_nxt;
  logic                 r_stop_idx;
  logic                 w_stop_idx_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic                 w_xfer;
  logic                 w_tick;
  logic                 w_run;
  logic [BYTE_W-1:0]    w_byte;

  assign o_accept  = (r_state == TX_IDLE) && !i_rst;
  assign w_xfer    = i_valid && o_accept;
  assign w_div_in  = (i_div == '0) ? DIV_W'(1) : i_div;
  // The timer loads straight from the port on the transfer edge, from the latch afterwards.
  assign w_div_sel = w_xfer ? w_div_in : r_div;
  assign w_run     = (w_state_nxt != TX_IDLE);
  assign w_byte    = r_req.data[{r_byte_idx, 3'b000} +: BYTE_W];

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_xfer),
    .i_en   (w_run),
    .i_div  (w_div_sel),
    .o_tick (w_tick)
  );

  // Word, byte count and divisor are captured only on a transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req <= '0;
      r_div <= '0;
    end else if (w_xfer) begin
      r_req.data   <= i_data;
      r_req.nbytes <= i_nbytes;
      r_div        <= w_div_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= TX_IDLE;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_run;
    end
  end

  // Next state advances on bit ticks; the line level is derived from the next state so o_tx is registered.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_tx_nxt       = 1'b1;

    case (r_state)
      TX_IDLE: begin
        if (w_xfer) begin
          w_state_nxt    = TX_START;
          w_bit_idx_nxt  = '0;
          w_byte_idx_nxt = '0;
          w_stop_idx_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (w_tick) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = HAS_PAR ? TX_PARITY : TX_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (w_tick) w_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_stop_idx == LAST_STOP) begin
            w_stop_idx_nxt = 1'b0;
            if (r_byte_idx == r_req.nbytes) begin
              w_byte_idx_nxt = '0;
              w_state_nxt    = TX_IDLE;
            end else begin
              w_byte_idx_nxt = r_byte_idx + 1'b1;
              w_state_nxt    = TX_START;
            end
          end else begin
            w_stop_idx_nxt = r_stop_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase

    case (w_state_nxt)
      TX_START:  w_tx_nxt = 1'b0;
      TX_DATA:   w_tx_nxt = w_byte[w_bit_idx_nxt];
      TX_PARITY: w_tx_nxt = char_parity(w_byte, DATA_BITS, PAR_INV);
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_word.sv
// Scoreboard bench for uart_tx_word: three parameter sets, a frame-level line model and a per-cycle monitor.
module tb_uart_tx_word;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  rst_seen = 3'b111;
  logic [2:0]  valid = 3'b000;
  logic [31:0] data [3];
  logic [1:0]  nb   [3];
  logic [15:0] dv   [3];
  wire  [2:0]  acc;
  wire  [2:0]  tx;
  wire  [2:0]  busy;

  bit exp_mem [3][DEPTH];
  int wr_p [3];
  int rd_p [3];
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_word #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_nbytes(nb[0]), .i_div(dv[0]),
    .i_valid(valid[0]), .o_accept(acc[0]), .o_tx(tx[0]), .o_busy(busy[0]));

  uart_tx_word #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_nbytes(nb[1]), .i_div(dv[1]),
    .i_valid(valid[1]), .o_accept(acc[1]), .o_tx(tx[1]), .o_busy(busy[1]));

  uart_tx_word #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u_dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_data(data[2]), .i_nbytes(nb[2]), .i_div(dv[2]),
    .i_valid(valid[2]), .o_accept(acc[2]), .o_tx(tx[2]), .o_busy(busy[2]));

  function automatic int cfg_db(input int i);  return (i == 2) ? 7 : 8; endfunction
  function automatic int cfg_par(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int cfg_sb(input int i);  return (i == 2) ? 2 : 1; endfunction

  function automatic void chk(input string nm, input int i, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got %b expected %b", nm, i, $time, act, exp);
    end
  endfunction

  task automatic push_bit(input int i, input bit v, input int reps);
    for (int r = 0; r < reps; r++) begin
      exp_mem[i][wr_p[i] % DEPTH] = v;
      wr_p[i]++;
    end
  endtask

  // Expected line level for every cycle of a word, built from the frame definition.
  task automatic push_word(input int i, input logic [31:0] d, input int n, input int dvr);
    int de;
    int ones;
    logic [7:0] by;
    de = (dvr == 0) ? 1 : dvr;
    for (int b = 0; b <= n; b++) begin
      by = d[8*b +: 8];
      ones = 0;
      push_bit(i, 1'b0, de);
      for (int k = 0; k < cfg_db(i); k++) begin
        push_bit(i, by[k], de);
        ones += int'(by[k]);
      end
      if (cfg_par(i) == 2) push_bit(i, bit'(ones % 2), de);
      else if (cfg_par(i) == 1) push_bit(i, bit'(1 - (ones % 2)), de);
      for (int s = 0; s < cfg_sb(i); s++) push_bit(i, 1'b1, de);
    end
  endtask

  always @(posedge clk) rst_seen <= rst;

  // Monitor: one expected line level per busy cycle; idle line and handshake otherwise.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_seen[i]) begin
        rd_p[i] = wr_p[i];
        chk("rst_tx", i, tx[i], 1'b1);
        chk("rst_busy", i, busy[i], 1'b0);
        chk("rst_accept", i, acc[i], !rst[i]);
      end else if (rd_p[i] != wr_p[i]) begin
        chk("line", i, tx[i], exp_mem[i][rd_p[i] % DEPTH]);
        rd_p[i]++;
        chk("busy", i, busy[i], 1'b1);
        chk("accept_busy", i, acc[i], 1'b0);
      end else begin
        chk("idle_tx", i, tx[i], 1'b1);
        chk("idle_busy", i, busy[i], 1'b0);
        chk("idle_accept", i, acc[i], !rst[i]);
      end
    end
  end

  task automatic send(input int i, input logic [31:0] d, input logic [1:0] n,
                      input logic [15:0] v, input bit hold);
    int g;
    bit got;
    g = 0;
    got = 1'b0;
    data[i] = d; nb[i] = n; dv[i] = v; valid[i] = 1'b1;
    while (!got && g < 3000) begin
      @(negedge clk); #1;
      if (acc[i] === 1'b1) begin
        @(posedge clk);
        push_word(i, d, int'(n), int'(v));
        got = 1'b1;
      end else begin
        @(posedge clk);
      end
      g++;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout inst%0d: got no accept, required accept within 3000 cycles", i);
    end
    #1;
    if (!hold) begin
      valid[i] = 1'b0;
      data[i] = $urandom; nb[i] = 2'($urandom); dv[i] = 16'($urandom);
    end
  endtask

  // Wait for the scoreboard to drain while scrambling the idle inputs.
  task automatic wait_idle(input int i);
    int g;
    g = 0;
    while (rd_p[i] != wr_p[i] && g < 5000) begin
      @(posedge clk); #1;
      if (!valid[i]) begin
        data[i] = $urandom; nb[i] = 2'($urandom); dv[i] = 16'($urandom);
      end
      g++;
    end
    if (rd_p[i] != wr_p[i]) begin
      n_checks++; n_err++;
      $display("FAIL drain_timeout inst%0d: got %0d pending, required 0", i, wr_p[i] - rd_p[i]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      data[i] = '0; nb[i] = '0; dv[i] = '0; wr_p[i] = 0; rd_p[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    send(0, 32'h0000_00A5, 2'd0, 16'd4, 1'b0);
    wait_idle(0);
    send(1, 32'h0301_FF00, 2'd3, 16'd1, 1'b0);
    wait_idle(1);
    send(2, 32'h0000_0080, 2'd0, 16'd2, 1'b0);
    wait_idle(2);

    send(0, $urandom, 2'd1, 16'd0, 1'b1);
    send(0, $urandom, 2'd0, 16'd0, 1'b1);
    send(0, $urandom, 2'd2, 16'd0, 1'b0);
    wait_idle(0);
    send(2, $urandom, 2'd1, 16'd0, 1'b1);
    send(2, $urandom, 2'd3, 16'd1, 1'b0);
    wait_idle(2);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) begin
        send(i, $urandom, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 5)), 1'b0);
        wait_idle(i);
      end
    end

    send(0, $urandom, 2'd3, 16'd3, 1'b0);
    repeat (43) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    send(0, 32'h0000_005A, 2'd0, 16'd1, 1'b0);
    wait_idle(0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
